// File: rtl/microwave_pkg.sv
// Shared constants and state encoding for the microwave keypad/timer front end.
// No ports (package).
package microwave_pkg;

  localparam int BCD_W              = 4;
  localparam int NUM_DIGITS_DEF     = 3;
  localparam int SEC_TENS_MAX_DEF   = 5;
  localparam int QUICK_SEC_TENS_DEF = 3;
  localparam int QUICK_MIN_ONES     = 0;
  localparam int QUICK_SEC_ONES     = 0;
  localparam int KEY_MAX            = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // True for a BCD digit 0..9; keypad codes 10..15 are function keys we ignore.
  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return code <= BCD_W'(KEY_MAX);
  endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Three-digit BCD entry register (M, S tens, S ones) with digit count.
// Ports:
//   clk, clrn          clock, async active-low reset
//   clr_i              zero digits and count
//   preset_i           load quick-start value (0, QUICK_SEC_TENS, 0)
//   sat_i              clamp seconds tens/ones to SEC_TENS_MAX / 9 when out of range
//   shift_i            shift key_i in at the seconds-ones end, count up
//   key_i              digit to shift in
//   min_ones_o, sec_tens_o, sec_ones_o   held digits
//   count_o            digits accepted so far
module digit_shift_reg
  import microwave_pkg::*;
#(
  parameter int CNT_W          = 2,
  parameter int SEC_TENS_MAX   = SEC_TENS_MAX_DEF,
  parameter int QUICK_SEC_TENS = QUICK_SEC_TENS_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             clr_i,
  input  logic             preset_i,
  input  logic             sat_i,
  input  logic             shift_i,
  input  logic [BCD_W-1:0] key_i,
  output logic [BCD_W-1:0] min_ones_o,
  output logic [BCD_W-1:0] sec_tens_o,
  output logic [BCD_W-1:0] sec_ones_o,
  output logic [CNT_W-1:0] count_o
);

  logic [BCD_W-1:0] min_ones_q, min_ones_d;
  logic [BCD_W-1:0] sec_tens_q, sec_tens_d;
  logic [BCD_W-1:0] sec_ones_q, sec_ones_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    count_d    = count_q;
    if (clr_i) begin
      min_ones_d = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
      count_d    = '0;
    end else if (preset_i) begin
      min_ones_d = BCD_W'(QUICK_MIN_ONES);
      sec_tens_d = BCD_W'(QUICK_SEC_TENS);
      sec_ones_d = BCD_W'(QUICK_SEC_ONES);
    end else if (sat_i) begin
      // 60..99 seconds entered: clamp to x:59 rather than reject the entry.
      if (sec_tens_q > BCD_W'(SEC_TENS_MAX)) begin
        sec_tens_d = BCD_W'(SEC_TENS_MAX);
        sec_ones_d = BCD_W'(KEY_MAX);
      end
    end else if (shift_i) begin
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = key_i;
      count_d    = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      count_q    <= '0;
    end else begin
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      count_q    <= count_d;
    end
  end

  assign min_ones_o = min_ones_q;
  assign sec_tens_o = sec_tens_q;
  assign sec_ones_o = sec_ones_q;
  assign count_o    = count_q;

endmodule

// File: rtl/time_entry.sv
// Keypad front end for the M:SS countdown chain: collects digits, saturates
// seconds, pulses the chain's parallel load, enables counting and ends the
// cook cycle on the chain's zero flag.
// Build option: QUICK_START_EN -- start in IDLE loads 0:30 (QUICK_SEC_TENS)
// and runs immediately; without it, start in IDLE does nothing.
// Ports:
//   clk, clrn                 clock, async active-low reset
//   key_valid, key_code       digit strobe and BCD code (10..15 ignored)
//   start_key, clear_key      start / abort strobes
//   timer_zero                chain reports all digits zero
//   min_ones, sec_tens, sec_ones   load values to the chain
//   loadn                     active-low parallel load strobe
//   en                        count enable
//   running                   high while counting
//   done                      one-cycle pulse at normal end of cook
//
// state    | meaning
// ST_IDLE  | no entry; digits zero
// ST_ENTRY | collecting digits
// ST_LOAD  | one-cycle parallel load into the chain
// ST_RUN   | chain counting down, waiting for zero
module time_entry
  import microwave_pkg::*;
#(
  parameter int NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter int SEC_TENS_MAX   = SEC_TENS_MAX_DEF,
  parameter int QUICK_SEC_TENS = QUICK_SEC_TENS_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_code,
  input  logic             start_key,
  input  logic             clear_key,
  input  logic             timer_zero,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             loadn,
  output logic             en,
  output logic             running,
  output logic             done
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  state_e state_q, state_d;
  logic   loadn_q, loadn_d;
  logic   en_q, en_d;
  logic   running_q, running_d;
  logic   done_q, done_d;

  logic             dig_clr, dig_preset, dig_sat, dig_shift;
  logic [CNT_W-1:0] count;
  logic             key_ok, any_nonzero;

  assign key_ok      = key_valid && is_digit(key_code);
  assign any_nonzero = |{min_ones, sec_tens, sec_ones};

  digit_shift_reg #(
    .CNT_W          (CNT_W),
    .SEC_TENS_MAX   (SEC_TENS_MAX),
    .QUICK_SEC_TENS (QUICK_SEC_TENS)
  ) u_digits (
    .clk        (clk),
    .clrn       (clrn),
    .clr_i      (dig_clr),
    .preset_i   (dig_preset),
    .sat_i      (dig_sat),
    .shift_i    (dig_shift),
    .key_i      (key_code),
    .min_ones_o (min_ones),
    .sec_tens_o (sec_tens),
    .sec_ones_o (sec_ones),
    .count_o    (count)
  );

  always_comb begin
    state_d    = state_q;
    dig_clr    = 1'b0;
    dig_preset = 1'b0;
    dig_sat    = 1'b0;
    dig_shift  = 1'b0;
    done_d     = 1'b0;
    if (clear_key) begin
      state_d = ST_IDLE;
      dig_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef QUICK_START_EN
          if (start_key) begin
            dig_preset = 1'b1;
            state_d    = ST_LOAD;
          end else
`endif
          if (key_ok) begin
            dig_shift = 1'b1;
            state_d   = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          // start owns the cycle: a digit arriving with it is dropped.
          if (start_key) begin
            if (any_nonzero) begin
              dig_sat = 1'b1;
              state_d = ST_LOAD;
            end
          end else if (key_ok && (count < CNT_W'(NUM_DIGITS))) begin
            dig_shift = 1'b1;
          end
        end
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (timer_zero) begin
            state_d = ST_IDLE;
            dig_clr = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_comb begin
    loadn_d   = (state_d != ST_LOAD);
    en_d      = (state_d == ST_LOAD) || (state_d == ST_RUN);
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      loadn_q   <= 1'b1;
      en_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      loadn_q   <= loadn_d;
      en_q      <= en_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign loadn   = loadn_q;
  assign en      = en_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: doc/time_entry.md
Name: time_entry

Overview:
- Keypad-side front end for the microwave countdown chain: collects BCD digits, validates them, and drives the parallel-load interface (in, loadn, en) of the timer digit counters (timer_six / timer_ten).
- Watches the chain's zero flag to end a cook cycle.
- Sits between the keypad decoder and the M:SS timer chain.

Parameters:
- NUM_DIGITS, 3, maximum digits accepted per entry (M, S tens, S ones).
- SEC_TENS_MAX, 5, highest legal seconds-tens value; larger values saturate.
- QUICK_SEC_TENS, 3, seconds-tens value preset by quick start (see Optional Feature).

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid.
- key_code  in  4  BCD digit 0-9; codes 10-15 ignored.
- start_key  in  1  one-cycle start strobe.
- clear_key  in  1  one-cycle clear/abort strobe.
- timer_zero  in  1  chain-wide zero flag (all digits 0).
- min_ones  out  4  load value, minutes digit.
- sec_tens  out  4  load value, seconds tens (0..SEC_TENS_MAX after load).
- sec_ones  out  4  load value, seconds ones.
- loadn  out  1  active-low parallel-load strobe to the timer chain.
- en  out  1  count enable to the timer chain.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when a cook cycle ends normally.

Behaviour:
- Reset (clrn=0, async): state IDLE; digit count 0; min_ones=sec_tens=sec_ones=0; loadn=1; en=0; running=0; done=0.
- States: IDLE, ENTRY, LOAD, RUN.
- Digit shift on an accepted key: sec_ones<=key_code, sec_tens<=old sec_ones, min_ones<=old sec_tens; count increments.
  - IDLE: key accepted, go to ENTRY.
  - ENTRY: key accepted while count<NUM_DIGITS; further keys ignored.
  - Codes >9 are ignored everywhere.
- start_key in ENTRY with any digit nonzero:
  - Saturate if sec_tens>SEC_TENS_MAX: sec_tens<=SEC_TENS_MAX, sec_ones<=9.
  - Go to LOAD.
  - start_key with all digits zero is ignored and the state stays ENTRY.
- LOAD (exactly 1 cycle): loadn=0, en=1. Outputs hold the saturated values. Next state RUN.
- RUN: loadn=1, en=1, running=1.
  - Digit keys and start_key are ignored.
  - timer_zero sampled high: go to IDLE next cycle, en=0, done=1 for that one cycle, digits cleared, count=0.
  - timer_zero is ignored in LOAD.
- clear_key:
  - Any state: go to IDLE, digits and count to 0, en=0, loadn=1, done stays 0.
  - Highest priority over key_valid, start_key and timer_zero in the same cycle.
- Simultaneous key_valid and start_key in ENTRY: start wins; the digit is discarded.
- Latency: start_key edge to loadn=0 is 1 cycle; to running=1 is 2 cycles.
- All outputs are registered.

Optional Feature:
- Macro QUICK_START_EN.
- Defined: start_key in IDLE (count=0) presets min_ones=0, sec_tens=QUICK_SEC_TENS, sec_ones=0 and goes directly to LOAD.
- Undefined: start_key in IDLE is ignored.

Decomposition:
- Shared package microwave_pkg:
  - state encoding (IDLE/ENTRY/LOAD/RUN, 2 bits)
  - BCD_W=4, SEC_TENS_MAX default, quick-start constants
  - key_code range constant 9
- One natural sub-module, digit_shift_reg: the 3x4-bit BCD shift register with count, clear and saturate controls. The FSM stays in time_entry.

Test Plan:
- Keys 1,3,0 then start -> (1,3,0) present; cycle+1 loadn=0 en=1; cycle+2 running=1 loadn=1.
- Keys 9,9 then start -> saturates to min=0, tens=5, ones=9 at LOAD.
- Keys 1,2,3,4 -> 4th ignored, outputs (1,2,3); key_code=12 -> no change.
- In RUN assert timer_zero -> next cycle IDLE, en=0, done pulse 1 cycle, digits 0.
- In RUN assert clear_key together with timer_zero -> IDLE, done stays 0. In ENTRY assert key_valid=5 together with start -> digit discarded. Pulse clrn low mid-RUN -> all outputs at reset values immediately.
- QUICK_START_EN defined: start in IDLE -> LOAD with (0,3,0). Undefined: no state change.
